instr_cache: RTL and testbench
==============================

Name: instr_cache

Overview:
- Read-only, direct-mapped instruction cache: the responder on the ICACHE interface driven by the fetch stage.
- The fetch stage issues word-addressed reads; this block returns data combinationally on a hit, or holds proc_stall high while it refills a 128-bit line from instruction memory.
- Sits between the fetch stage and the instruction-memory slow-memory model.

Parameters:
- NUM_LINES, 8, number of cache lines; power of 2, minimum 2.
- IDX_W, log2(NUM_LINES) = 3, index width; derived localparam, not overridable.
- TAG_W, 28-IDX_W = 25, tag width; derived localparam.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- proc_read  input  1  fetch read request (ICACHE_ren).
- proc_write  input  1  fetch write request (ICACHE_wen); ignored.
- proc_addr  input  30  word address: [1:0] word-in-line, [IDX_W+1:2] index, [29:IDX_W+2] tag.
- proc_wdata  input  32  ignored.
- proc_rdata  output  32  read data; valid when proc_read=1 and proc_stall=0.
- proc_stall  output  1  high while the requested word is not available.
- mem_read  output  1  line-fill request to instruction memory.
- mem_write  output  1  tied 0.
- mem_addr  output  28  line address = proc_addr[29:2] latched at miss.
- mem_wdata  output  128  tied 0.
- mem_rdata  input  128  fill data; word0 in [31:0], word3 in [127:96].
- mem_ready  input  1  fill complete; mem_rdata is valid in the same cycle.

Behaviour:
- Storage: per line valid bit, TAG_W tag, 128-bit data. Reset clears all valid bits; tag/data are not reset.
- hit = proc_read & valid[idx] & (tag[idx]==proc_addr tag), evaluated combinationally.
- proc_rdata = data[idx] word selected by proc_addr[1:0] on a hit; otherwise 0.
- FSM states:
  - IDLE: proc_stall = proc_read & ~hit.
    - Hit: zero-latency response, stay IDLE.
    - Miss: latch the line address into miss_addr and go to FETCH. mem_read rises in the next cycle (registered).
  - FETCH: mem_read=1, mem_addr=miss_addr, proc_stall=1.
    - On mem_ready: write mem_rdata into line miss_addr[IDX_W-1:0], set its tag and valid bit, drop mem_read in the next cycle, go to DONE.
  - DONE: mem_read=0, proc_stall=1 for one cycle, then return to IDLE. The hit is re-evaluated in IDLE, so the miss-to-data penalty is memory latency + 2 cycles.
- proc_read deasserted or proc_addr changed during FETCH: the fill is never aborted. It completes for miss_addr. The new address is evaluated in IDLE.
- proc_write=1 has no effect on state; proc_stall follows proc_read only.
- Outputs at reset: proc_stall=0, proc_rdata=0, mem_read=0, mem_addr=0, mem_write=0, mem_wdata=0, state=IDLE.
- Reset asserted mid-FETCH: the next edge returns to IDLE with mem_read=0 and all valid bits cleared. A later mem_ready is ignored outside FETCH.
- Index wrap: proc_addr tag and index differing only in the tag evict the resident line (direct-mapped replacement).

Optional Feature:
- ICACHE_STATS_EN.
- Defined: adds outputs hit_count[31:0] and miss_count[31:0], reset to 0.
  - hit_count increments in every IDLE cycle with proc_read & hit.
  - miss_count increments on each IDLE->FETCH transition.
  - Both wrap modulo 2^32.
- Undefined: the ports and counters are absent. Functional behaviour is identical.

Test Plan:
- Reset, then proc_read=1 with proc_addr=0x0000_0000 -> proc_stall=1; mem_read=1 with mem_addr=0 one cycle later; mem_ready for 1 cycle with mem_rdata={32'h4,32'h3,32'h2,32'h1} -> two cycles later proc_stall=0 and proc_rdata=0x00000001.
- After the fill, read addrs 0x1, 0x2, 0x3 on consecutive cycles -> proc_stall=0 each cycle; rdata=0x2, 0x3, 0x4; mem_read stays 0.
- Conflict: read 0x0000_0020 (same index 0, new tag) -> miss, mem_addr=0x0000008; then read 0x0 -> misses again (eviction).
- Drop proc_read and change proc_addr to 0x4 during FETCH -> fill of the original line still completes; in IDLE, 0x4 is evaluated as a fresh miss.
- Assert rst_n=0 for one cycle mid-FETCH -> mem_read=0 next cycle; a subsequent read of a previously filled address misses.
- ICACHE_STATS_EN defined: run scenarios 1-2 -> miss_count=1 and hit_count=4 (including the post-fill hit on 0x0).

Source files
------------

// File: rtl/instr_cache.sv
`default_nettype none
// ============================================================================
//  Module   : instr_cache
//  Brief    : Read-only direct-mapped instruction cache with 128-bit line
//             refill from instruction memory. Hits return data
//             combinationally; misses stall the fetch stage while the line
//             is refilled.
//  Options  : define ICACHE_STATS_EN to add hit_count / miss_count outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_cache #(
    parameter int NUM_LINES = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
`ifdef ICACHE_STATS_EN
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count,
`endif
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [27:0]          miss_addr_q, miss_addr_d;
    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [127:0]         data_q [NUM_LINES];

    logic [IDX_W-1:0]     w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic                 w_hit;
    logic                 w_fill;
    logic [IDX_W-1:0]     w_fill_idx;
    logic [TAG_W-1:0]     w_fill_tag;
    logic [127:0]         w_line;
    logic [6:0]           w_word_lsb;

    // Write port and write data are meaningless for an instruction cache.
    logic unused_inputs;
    assign unused_inputs = ^{proc_write, proc_wdata};

    assign w_idx      = proc_addr[IDX_W+1:2];
    assign w_tag      = proc_addr[29:IDX_W+2];
    assign w_line     = data_q[w_idx];
    assign w_word_lsb = {proc_addr[1:0], 5'b0_0000};
    assign w_hit      = proc_read & valid_q[w_idx] & (tag_q[w_idx] == w_tag);
    assign proc_rdata = w_hit ? w_line[w_word_lsb +: 32] : 32'h0;

    // A refill only lands while FETCH is waiting; stray mem_ready is ignored.
    assign w_fill     = (state_q == S_FETCH) & mem_ready;
    assign w_fill_idx = miss_addr_q[IDX_W-1:0];
    assign w_fill_tag = miss_addr_q[27:IDX_W];

    assign mem_addr   = miss_addr_q;
    assign mem_write  = 1'b0;
    assign mem_wdata  = '0;

    // Next-state and output decode for the miss/refill sequencer.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        proc_stall  = 1'b0;
        mem_read    = 1'b0;
        case (state_q)
            S_IDLE: begin
                proc_stall = proc_read & ~w_hit;
                if (proc_read && !w_hit) begin
                    miss_addr_d = proc_addr[29:2];
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                if (mem_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // One settling cycle so the hit is re-evaluated from IDLE.
                proc_stall = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state: FSM, latched miss line address and valid bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            miss_addr_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            if (w_fill) begin
                valid_q[w_fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays; contents are qualified by valid, so no reset.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            tag_q[w_fill_idx]  <= w_fill_tag;
            data_q[w_fill_idx] <= mem_rdata;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    // Performance counters; both wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (w_hit) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if (proc_read && !w_hit) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_cache.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_cache
//  Brief    : Self-checking bench for instr_cache with a latency-programmable
//             instruction-memory responder and a read-data scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_cache;

    logic         clk;
    logic         rst_n;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
`ifdef ICACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int total = 0;
    int bad   = 0;
    int mem_lat = 1;
    int fills   = 0;
    logic [31:0] sb_q[$];

    instr_cache #(.NUM_LINES(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
`ifdef ICACHE_STATS_EN
        .hit_count  (hit_count),
        .miss_count (miss_count),
`endif
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory content model: word at word-address A holds A+1.
    function automatic logic [127:0] line_of(input logic [27:0] la);
        logic [31:0] b;
        b = {2'b00, la, 2'b00};
        return {b + 32'd4, b + 32'd3, b + 32'd2, b + 32'd1};
    endfunction

    // Instruction-memory responder: one-cycle mem_ready pulse after mem_lat cycles.
    initial begin
        int cnt;
        cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ready) begin
                mem_ready = 1'b0;
                cnt = 0;
            end else if (mem_read && rst_n) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = line_of(mem_addr);
                    fills++;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one read, scoreboard its data, check stall length and fill address.
    task automatic do_read(input logic [29:0] a, input bit exp_hit);
        int  stalls;
        bit  done;
        bit  addr_chk;
        logic [31:0] exp;
        proc_read = 1'b1;
        proc_addr = a;
        sb_q.push_back(32'(a) + 32'd1);
        stalls   = 0;
        done     = 1'b0;
        addr_chk = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (!proc_stall) begin
                exp = sb_q.pop_front();
                total++;
                if (proc_rdata !== exp) begin
                    bad++;
                    $display("FAIL rdata addr=%h got=%h exp=%h", a, proc_rdata, exp);
                end
                total++;
                if (mem_read !== 1'b0) begin
                    bad++;
                    $display("FAIL mem_read_on_hit addr=%h got=%b exp=0", a, mem_read);
                end
                done = 1'b1;
            end else begin
                stalls++;
                if (mem_read && !addr_chk) begin
                    addr_chk = 1'b1;
                    total++;
                    if (mem_addr !== a[29:2]) begin
                        bad++;
                        $display("FAIL mem_addr addr=%h got=%h exp=%h", a, mem_addr, a[29:2]);
                    end
                end
            end
            step();
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL read_timeout addr=%h still stalled", a);
            sb_q.delete();
        end else if (stalls != (exp_hit ? 0 : mem_lat + 2)) begin
            bad++;
            $display("FAIL stall_cycles addr=%h got=%0d exp=%0d", a, stalls,
                     exp_hit ? 0 : mem_lat + 2);
        end
        proc_read = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        total++;
        if ({proc_stall, mem_read, mem_write} !== 3'b000 || proc_rdata !== 32'h0 ||
            mem_addr !== 28'h0 || mem_wdata !== 128'h0) begin
            bad++;
            $display("FAIL reset_outputs got stall=%b mrd=%b mwr=%b rdata=%h maddr=%h exp all zero",
                     proc_stall, mem_read, mem_write, proc_rdata, mem_addr);
        end
        step();
    endtask

    task automatic test_fill_and_hits();
        mem_lat = 1;
        do_read(30'h0, 1'b0);
        do_read(30'h1, 1'b1);
        do_read(30'h2, 1'b1);
        do_read(30'h3, 1'b1);
`ifdef ICACHE_STATS_EN
        @(negedge clk);
        total++;
        if (miss_count !== 32'd1 || hit_count !== 32'd4) begin
            bad++;
            $display("FAIL stats got miss=%0d hit=%0d exp miss=1 hit=4", miss_count, hit_count);
        end
        step();
`endif
    endtask

    task automatic test_conflict();
        mem_lat = 3;
        do_read(30'h20, 1'b0);
        do_read(30'h0, 1'b0);
        do_read(30'h8, 1'b0);
        do_read(30'hB, 1'b1);
    endtask

    task automatic test_drop_during_fetch();
        int f0;
        mem_lat   = 2;
        f0        = fills;
        proc_read = 1'b1;
        proc_addr = 30'h40;
        step();
        proc_read = 1'b0;
        proc_addr = 30'h4;
        @(negedge clk);
        total++;
        if (proc_stall !== 1'b1 || mem_read !== 1'b1) begin
            bad++;
            $display("FAIL fetch_hold got stall=%b mrd=%b exp 1 1", proc_stall, mem_read);
        end
        for (int i = 0; i < 8; i++) step();
        @(negedge clk);
        total++;
        if (fills - f0 != 1 || mem_read !== 1'b0 || proc_stall !== 1'b0) begin
            bad++;
            $display("FAIL drop_fill got fills=%0d mrd=%b stall=%b exp 1 0 0",
                     fills - f0, mem_read, proc_stall);
        end
        step();
        do_read(30'h4, 1'b0);
        do_read(30'h41, 1'b1);
    endtask

    task automatic test_reset_mid_fetch();
        mem_lat   = 20;
        proc_read = 1'b1;
        proc_addr = 30'h10;
        step();
        step();
        proc_read = 1'b0;
        rst_n     = 1'b0;
        step();
        rst_n     = 1'b1;
        @(negedge clk);
        total++;
        if (mem_read !== 1'b0 || proc_stall !== 1'b0 || mem_addr !== 28'h0) begin
            bad++;
            $display("FAIL reset_mid_fetch got mrd=%b stall=%b maddr=%h exp 0 0 0",
                     mem_read, proc_stall, mem_addr);
        end
        step();
        mem_lat = 1;
        do_read(30'h8, 1'b0);
        do_read(30'h9, 1'b1);
    endtask

    task automatic test_back_to_back();
        mem_lat = 1;
        for (int i = 0; i < 4; i++) do_read(30'(32'h100 + 4 * i), 1'b0);
        for (int i = 0; i < 4; i++) do_read(30'(32'h100 + 4 * i + 3), 1'b1);
    endtask

    initial begin
        rst_n      = 1'b0;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        step();
        test_reset();
        test_fill_and_hits();
        test_conflict();
        test_drop_during_fetch();
        test_reset_mid_fetch();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
